// File: rtl/tmds_link_encoder.sv
// tmds_link_encoder: three-channel TMDS encoder (DVI, or HDMI with preamble/guard insertion)
// Samples run through an L-deep lookahead line; the de bits ahead of the tail decide preamble/guard.
module tmds_link_encoder #(
    parameter int HDMI_MODE    = 1,
    parameter int PREAMBLE_LEN = 8,
    parameter int GUARD_LEN    = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       de,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic [9:0] tmds_r,
    output logic [9:0] tmds_g,
    output logic [9:0] tmds_b,
    output logic [1:0] period
);
    localparam int L = (HDMI_MODE != 0) ? PREAMBLE_LEN + GUARD_LEN : 0;
    localparam logic [9:0] CTL0  = 10'b1101010100;
    localparam logic [9:0] CTL1  = 10'b0010101011;
    localparam logic [9:0] GB_RB = 10'b1011001100;
    localparam logic [9:0] GB_G  = 10'b0100110011;

    function automatic logic [9:0] ctl(input logic [1:0] c);
        return c == 2'd0 ? 10'b1101010100 : c == 2'd1 ? 10'b0010101011 :
               c == 2'd2 ? 10'b0101010100 : 10'b1010101011;
    endfunction

    // Returns {next disparity[4:0], symbol[9:0]}
    function automatic logic [14:0] enc(input logic [7:0] d, input logic signed [4:0] disp);
        logic [8:0] q;
        logic [9:0] o;
        logic xn;
        int n1d, n1, diff, nd;
        n1d = 0;
        for (int i = 0; i < 8; i++) n1d += int'(d[i]);
        xn = n1d > 4 || (n1d == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : q[i-1] ^ d[i];
        q[8] = ~xn;
        n1 = 0;
        for (int i = 0; i < 8; i++) n1 += int'(q[i]);
        diff = 2 * n1 - 8;
        if (disp == 0 || n1 == 4) begin
            o  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            nd = int'(disp) + (q[8] ? diff : -diff);
        end else if ((disp > 0 && n1 > 4) || (disp < 0 && n1 < 4)) begin
            o  = {1'b1, q[8], ~q[7:0]};
            nd = int'(disp) + 2 * int'(q[8]) - diff;
        end else begin
            o  = {1'b0, q[8], q[7:0]};
            nd = int'(disp) + diff - 2 * int'(!q[8]);
        end
        return {nd[4:0], o};
    endfunction

    // Sample word: {valid, de, vsync, hsync, red, green, blue}; valid=0 marks flushed slots
    logic [27:0] in_s, tail;
    logic        pre_any, guard_any;
    assign in_s = {1'b1, de, vsync, hsync, red, green, blue};

    generate
        if (L > 0) begin : g_dl
            localparam int P = L - GUARD_LEN;
            logic [27:0] dl_q [L];
            logic [L-1:0] la;
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < L; i++) dl_q[i] <= '0;
                end else begin
                    dl_q[0] <= in_s;
                    for (int i = 1; i < L; i++) dl_q[i] <= dl_q[i-1];
                end
            end
            assign tail = dl_q[L-1];
            // la[j] is the de of the sample L-j positions after the tail
            always_comb begin
                la[0] = de;
                for (int j = 1; j < L; j++) la[j] = dl_q[j-1][26];
            end
            always_comb begin
                pre_any   = 1'b0;
                guard_any = 1'b0;
                for (int j = 0; j < L; j++) begin
                    if (j < P) pre_any = pre_any | la[j];
                    else guard_any = guard_any | la[j];
                end
            end
        end else begin : g_nodl
            assign tail      = in_s;
            assign pre_any   = 1'b0;
            assign guard_any = 1'b0;
        end
    endgenerate

    logic [9:0]        r_q, g_q, b_q, r_d, g_d, b_d, er, eg, eb;
    logic [1:0]        period_q, cls;
    logic signed [4:0] dr_q, dg_q, db_q, dr_d, dg_d, db_d, dr_v, dg_v, db_v;

    // A blanking tail sample's first de=1 ahead is necessarily its nearest rise
    always_comb begin
        cls = !tail[27] ? 2'b00 : tail[26] ? 2'b11 : guard_any ? 2'b10 : pre_any ? 2'b01 : 2'b00;
        {dr_v, er} = enc(tail[23:16], dr_q);
        {dg_v, eg} = enc(tail[15:8], dg_q);
        {db_v, eb} = enc(tail[7:0], db_q);
        r_d  = cls == 2'b11 ? er : cls == 2'b10 ? GB_RB : CTL0;
        g_d  = cls == 2'b11 ? eg : cls == 2'b10 ? GB_G : cls == 2'b01 ? CTL1 : CTL0;
        b_d  = cls == 2'b11 ? eb : cls == 2'b10 ? GB_RB : ctl(tail[25:24]);
        dr_d = cls == 2'b11 ? dr_v : 5'sd0;
        dg_d = cls == 2'b11 ? dg_v : 5'sd0;
        db_d = cls == 2'b11 ? db_v : 5'sd0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q      <= CTL0;
            g_q      <= CTL0;
            b_q      <= CTL0;
            period_q <= 2'b00;
            dr_q     <= 5'sd0;
            dg_q     <= 5'sd0;
            db_q     <= 5'sd0;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            period_q <= cls;
            dr_q     <= dr_d;
            dg_q     <= dg_d;
            db_q     <= db_d;
        end
    end

    assign tmds_r = r_q;
    assign tmds_g = g_q;
    assign tmds_b = b_q;
    assign period = period_q;
endmodule

// File: tb/tb_tmds_link_encoder.sv
// tb_tmds_link_encoder: directed + random checks of three encoder configurations against a sample-history model
module tb_tmds_link_encoder;
    localparam int N = 4096;
    localparam logic [9:0] C0  = 10'b1101010100;
    localparam logic [9:0] C1  = 10'b0010101011;
    localparam logic [9:0] C3  = 10'b1010101011;
    localparam logic [9:0] GBR = 10'b1011001100;
    localparam logic [9:0] GBG = 10'b0100110011;
    localparam logic [9:0] V0  = 10'b0100000000;
    localparam logic [9:0] V1  = 10'b1111111111;

    logic       clk = 1'b0, reset = 1'b1, de = 1'b0, hsync = 1'b0, vsync = 1'b0;
    logic [7:0] red = '0, green = '0, blue = '0;
    logic [9:0] tr [3], tg [3], tbl [3];
    logic [1:0] per [3];

    always #5 clk = ~clk;

    tmds_link_encoder u_hdmi (.clk(clk), .reset(reset), .de(de), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .tmds_r(tr[0]), .tmds_g(tg[0]), .tmds_b(tbl[0]), .period(per[0]));
    tmds_link_encoder #(.HDMI_MODE(0)) u_dvi (.clk(clk), .reset(reset), .de(de), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .tmds_r(tr[1]), .tmds_g(tg[1]), .tmds_b(tbl[1]), .period(per[1]));
    tmds_link_encoder #(.PREAMBLE_LEN(0), .GUARD_LEN(3)) u_alt (.clk(clk), .reset(reset), .de(de), .hsync(hsync),
        .vsync(vsync), .red(red), .green(green), .blue(blue), .tmds_r(tr[2]), .tmds_g(tg[2]), .tmds_b(tbl[2]),
        .period(per[2]));

    bit         de_h [N], hs_h [N], vs_h [N], rst_h [N];
    logic [7:0] r_h [N], g_h [N], b_h [N];
    int         ll [3] = '{10, 0, 3};
    int         gl [3] = '{2, 0, 3};
    logic [9:0] ctl_t [4] = '{C0, C1, 10'b0101010100, C3};
    int         dsp [3][3];
    int         cyc = 0, checks = 0, failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [9:0] tm(input logic [7:0] d, input int dv, output int nd);
        int n, a, z;
        logic xn;
        logic [8:0] q;
        logic [9:0] o;
        n = $countones(d);
        xn = (n > 4) || (n == 4 && !d[0]);
        q[0] = d[0];
        for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
        q[8] = !xn;
        a = $countones(q[7:0]);
        z = 8 - a;
        if ((dv > 0 && a > z) || (dv < 0 && z > a)) begin
            o  = {1'b1, q[8], ~q[7:0]};
            nd = dv + 2 * int'(q[8]) + z - a;
        end else if (dv == 0 || a == z) begin
            o  = {~q[8], q[8], q[8] ? q[7:0] : ~q[7:0]};
            nd = q[8] ? dv + a - z : dv + z - a;
        end else begin
            o  = {1'b0, q[8], q[7:0]};
            nd = dv + a - z - (q[8] ? 0 : 2);
        end
        return o;
    endfunction

    // Expected {period, r, g, b} at output cycle oc for unit u, from the recorded input history
    function automatic logic [31:0] model(input int u, input int oc);
        int s, k, nd;
        bit dead;
        logic [9:0] r, g, b;
        s = oc - ll[u] - 1;
        dead = 1'b0;
        for (int t = s; t < oc; t++) begin
            if (t < 0) dead = 1'b1;
            else if (rst_h[t]) dead = 1'b1;
        end
        if (dead) begin
            for (int c = 0; c < 3; c++) dsp[u][c] = 0;
            return {2'b00, C0, C0, C0};
        end
        if (de_h[s]) begin
            r = tm(r_h[s], dsp[u][0], nd); dsp[u][0] = nd;
            g = tm(g_h[s], dsp[u][1], nd); dsp[u][1] = nd;
            b = tm(b_h[s], dsp[u][2], nd); dsp[u][2] = nd;
            return {2'b11, r, g, b};
        end
        for (int c = 0; c < 3; c++) dsp[u][c] = 0;
        k = 0;
        for (int j = ll[u]; j >= 1; j--) if (de_h[s+j] && !de_h[s+j-1]) k = j;
        if (k == 0) return {2'b00, C0, C0, ctl_t[{vs_h[s], hs_h[s]}]};
        if (k <= gl[u]) return {2'b10, GBR, GBG, GBR};
        return {2'b01, C0, C1, ctl_t[{vs_h[s], hs_h[s]}]};
    endfunction

    task automatic step();
        de_h[cyc] = de; hs_h[cyc] = hsync; vs_h[cyc] = vsync; rst_h[cyc] = reset;
        r_h[cyc] = red; g_h[cyc] = green; b_h[cyc] = blue;
        @(posedge clk);
        cyc++;
        @(negedge clk);
        chk("model_hdmi", {per[0], tr[0], tg[0], tbl[0]}, model(0, cyc));
        chk("model_dvi", {per[1], tr[1], tg[1], tbl[1]}, model(1, cyc));
        chk("model_alt", {per[2], tr[2], tg[2], tbl[2]}, model(2, cyc));
    endtask

    initial begin
        int t, o, vcnt, nb, nv;
        de = 1'b1; red = 8'hFF; green = 8'hFF; blue = 8'hFF;
        for (int i = 0; i < 13; i++) begin
            reset = (i < 3);
            step();
            chk("rst_hold_hdmi", {per[0], tr[0], tg[0], tbl[0]}, {2'b00, C0, C0, C0});
            if (i < 3) chk("rst_hold_dvi", {per[1], tr[1], tg[1], tbl[1]}, {2'b00, C0, C0, C0});
        end
        for (int i = 0; i < 3; i++) step();
        de = 1'b0; hsync = 1'b1; vsync = 1'b0;
        step();
        chk("dvi_hsync", {tr[1], tg[1], tbl[1]}, {C0, C0, C1});
        vsync = 1'b1;
        step();
        chk("dvi_vhsync", {tr[1], tg[1], tbl[1]}, {C0, C0, C3});
        hsync = 1'b0; vsync = 1'b0; red = 8'h00; green = 8'h00; blue = 8'h00;
        for (int i = 0; i < 20; i++) step();
        t = cyc;
        for (int i = 0; i < 22; i++) begin
            de = (i < 3 || i == 4);
            step();
            o = cyc - t;
            if (o >= 1 && o <= 8) chk("line_preamble", {per[0], tr[0], tg[0]}, {2'b01, C0, C1});
            if (o == 9 || o == 10 || o == 14) chk("line_guard", {per[0], tr[0], tg[0], tbl[0]}, {2'b10, GBR, GBG, GBR});
            if (o == 11 || o == 13 || o == 15) chk("disp_v0_hdmi", {per[0], tr[0], tg[0], tbl[0]}, {2'b11, V0, V0, V0});
            if (o == 12) chk("disp_v1_hdmi", {per[0], tr[0], tg[0], tbl[0]}, {2'b11, V1, V1, V1});
            if (o == 1 || o == 3 || o == 5) chk("disp_v0_dvi", {per[1], tr[1], tg[1], tbl[1]}, {2'b11, V0, V0, V0});
            if (o == 2) chk("disp_v1_dvi", {per[1], tr[1], tg[1], tbl[1]}, {2'b11, V1, V1, V1});
        end
        t = cyc;
        vcnt = 0;
        for (int i = 0; i < 31; i++) begin
            de = (i < 6) || (i >= 10 && i < 16);
            red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
            step();
            o = cyc - t;
            if (per[0] == 2'b11) vcnt++;
            if (o == 17 || o == 18) chk("short_pre", {30'd0, per[0]}, {30'd0, 2'b01});
            if (o == 19 || o == 20) chk("short_guard", {30'd0, per[0]}, {30'd0, 2'b10});
        end
        chk("short_video_count", vcnt, 32'd12);
        de = 1'b0;
        for (int i = 0; i < 12; i++) step();
        t = cyc;
        de = 1'b1;
        for (int i = 0; i < 20; i++) begin
            reset = (i == 3);
            step();
            o = cyc - t;
            if (o >= 1 && o <= 3) chk("midrst_pre", {30'd0, per[0]}, {30'd0, 2'b01});
            if (o >= 4 && o <= 14) chk("midrst_flush", {per[0], tr[0], tg[0], tbl[0]}, {2'b00, C0, C0, C0});
            if (o == 15) chk("midrst_video", {30'd0, per[0]}, {30'd0, 2'b11});
        end
        reset = 1'b0;
        while (cyc < 2500) begin
            nb = $urandom_range(0, 14);
            nv = $urandom_range(1, 20);
            for (int i = 0; i < nb; i++) begin
                de = 1'b0;
                hsync = 1'($urandom_range(0, 1));
                vsync = 1'($urandom_range(0, 1));
                red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
                reset = ($urandom_range(0, 59) == 0);
                step();
            end
            for (int i = 0; i < nv; i++) begin
                de = 1'b1; reset = 1'b0;
                red = 8'($urandom); green = 8'($urandom); blue = 8'($urandom);
                step();
            end
        end
        de = 1'b0; reset = 1'b0;
        for (int i = 0; i < 15; i++) step();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
